// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Writer side of the register-file write port. ALU results and load-unit
// responses share the single W1/W_EN/W_data port. ALU results always win;
// loads that cannot be written immediately wait in a small in-order queue.
// Writes to x0 are dropped, and a queued or incoming load that is overtaken
// by a younger ALU write to the same register is killed so it can never
// clobber the newer value. Read-after-write hazards are flagged to decode.
//
// Optional feature macro: WB_FWD_EN
//   defined   : adds fwd1_hit/fwd1_data and fwd2_hit/fwd2_data so decode can
//               take the value being written this cycle; a match against
//               wb_* then no longer stalls, only queue matches do.
//   undefined : no forwarding ports; a match against wb_* also stalls.
//
// Parameters
//   DATA_W    register data width
//   ADDR_W    register index width
//   LQ_DEPTH  load-queue entries (power of 2, >= 2)
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   alu_valid/rd/data     ALU result, always accepted
//   ld_valid/rd/data      load response, accepted when ld_valid && ld_ready
//   ld_ready              load queue not full (from registered count)
//   rs1, rs2              decode-stage source registers
//   hz_stall              decode must stall on a pending write
//   wb_en/addr/data       registered regfile write port
//   fwd1_*, fwd2_*        forwarding taps (WB_FWD_EN only)
// -----------------------------------------------------------------------------
module wb_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int LQ_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_rd,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic              hz_stall,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data
`ifdef WB_FWD_EN
   ,
   output logic              fwd1_hit,
   output logic [DATA_W-1:0] fwd1_data,
   output logic              fwd2_hit,
   output logic [DATA_W-1:0] fwd2_data
`endif
);

   localparam int PTR_W = $clog2(LQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Which source drives the write port in the next cycle.
   typedef enum logic [1:0] {
      SRC_NONE  = 2'd0,
      SRC_ALU   = 2'd1,
      SRC_QUEUE = 2'd2,
      SRC_LOAD  = 2'd3
   } wb_src_e;

   // ---------------------------------------------------------------------------
   // Load queue storage
   // ---------------------------------------------------------------------------
   logic [ADDR_W-1:0] q_rd   [LQ_DEPTH];
   logic [DATA_W-1:0] q_data [LQ_DEPTH];
   logic [LQ_DEPTH-1:0] q_valid;
   logic [LQ_DEPTH-1:0] q_kill;
   logic [LQ_DEPTH-1:0] q_live;
   logic [LQ_DEPTH-1:0] kill_hit;

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   // ---------------------------------------------------------------------------
   // Per-cycle decisions
   // ---------------------------------------------------------------------------
   logic    alu_sel;
   logic    q_empty;
   logic    pop;
   logic    ld_acc;
   logic    ld_nz;
   logic    ld_direct;
   logic    ld_killed;
   logic    push;
   wb_src_e src;

   logic              next_en;
   logic [ADDR_W-1:0] next_addr;
   logic [DATA_W-1:0] next_data;

   logic q_hit1;
   logic q_hit2;
   logic wb_hit1;
   logic wb_hit2;

   // ld_ready looks only at the registered count, so a pop this cycle does
   // not open a slot until the following cycle.
   assign ld_ready  = (count != CNT_W'(LQ_DEPTH));
   assign ld_acc    = ld_valid && ld_ready;
   assign ld_nz     = (ld_rd != '0);
   assign alu_sel   = alu_valid && (alu_rd != '0);
   assign q_empty   = (count == '0);

   // The queue only drains in cycles the ALU leaves the port free.
   assign pop       = !alu_sel && !q_empty;

   // Direct bypass keeps ordering intact because it is only allowed while
   // nothing older is waiting in the queue.
   assign ld_direct = ld_acc && ld_nz && !alu_sel && q_empty;

   // An ALU write is younger than any load arriving in the same cycle, so a
   // same-register load is accepted and silently dropped.
   assign ld_killed = alu_sel && (ld_rd == alu_rd);
   assign push      = ld_acc && ld_nz && !ld_direct && !ld_killed;

   assign q_live    = q_valid & ~q_kill;

   // Source selection and next write-port values.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      src       = SRC_NONE;
      next_en   = 1'b0;
      next_addr = wb_addr;
      next_data = wb_data;

      if (alu_sel) begin
         src = SRC_ALU;
      end else if (!q_empty) begin
         src = SRC_QUEUE;
      end else if (ld_direct) begin
         src = SRC_LOAD;
      end

      unique case (src)
         SRC_ALU: begin
            next_en   = 1'b1;
            next_addr = alu_rd;
            next_data = alu_data;
         end
         SRC_QUEUE: begin
            // A killed head is still popped, but the port stays idle and
            // the previous address/data are held.
            if (q_live[head]) begin
               next_en   = 1'b1;
               next_addr = q_rd[head];
               next_data = q_data[head];
            end
         end
         SRC_LOAD: begin
            next_en   = 1'b1;
            next_addr = ld_rd;
            next_data = ld_data;
         end
         default: begin
            next_en = 1'b0;
         end
      endcase
   end

   // Live entries overtaken by this cycle's ALU write, plus hazard matches.
   always_comb begin
      kill_hit = '0;
      q_hit1   = 1'b0;
      q_hit2   = 1'b0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
         if (q_live[i] && alu_sel && (q_rd[i] == alu_rd)) begin
            kill_hit[i] = 1'b1;
         end
         if (q_live[i] && (q_rd[i] == rs1)) begin
            q_hit1 = 1'b1;
         end
         if (q_live[i] && (q_rd[i] == rs2)) begin
            q_hit2 = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Queue control state
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         q_valid <= '0;
         q_kill  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values regardless of statement order.
         q_kill <= q_kill | kill_hit;

         if (pop) begin
            q_valid[head] <= 1'b0;
            head          <= head + PTR_W'(1);
         end

         // The tail slot is never live while a push is possible, so its
         // kill bit can be cleared here without racing a kill above.
         if (push) begin
            q_valid[tail] <= 1'b1;
            q_kill[tail]  <= 1'b0;
            tail          <= tail + PTR_W'(1);
         end

         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: the payload array has no reset; q_valid gates every use of it,
   // so clearing it would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[tail]   <= ld_rd;
         q_data[tail] <= ld_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Registered write port
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_en   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
      end else begin
         wb_en   <= next_en;
         wb_addr <= next_addr;
         wb_data <= next_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Hazard detection / forwarding
   // ---------------------------------------------------------------------------
   assign wb_hit1 = wb_en && (wb_addr == rs1);
   assign wb_hit2 = wb_en && (wb_addr == rs2);

`ifdef WB_FWD_EN
   // The value on wb_* is handed straight to decode, so only loads still
   // waiting in the queue force a stall.
   assign fwd1_hit  = wb_hit1 && (rs1 != '0);
   assign fwd2_hit  = wb_hit2 && (rs2 != '0);
   assign fwd1_data = wb_data;
   assign fwd2_data = wb_data;
   assign hz_stall  = ((rs1 != '0) && q_hit1) ||
                      ((rs2 != '0) && q_hit2);
`else
   // Without forwarding, the register being written this cycle is not yet
   // visible through the regfile read ports.
   assign hz_stall  = ((rs1 != '0) && (q_hit1 || wb_hit1)) ||
                      ((rs2 != '0) && (q_hit2 || wb_hit2));
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed bench for wb_arbiter (default build). Stimulus pushes each expected
// register write into a scoreboard queue in the order it must appear; a
// monitor on the falling edge pops and compares whenever wb_en is high.
// Side signals (ld_ready, hz_stall, held wb_* values) are checked inline.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        hz_stall;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   wb_arbiter #(.DATA_W(32), .ADDR_W(5), .LQ_DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_rd     (ld_rd),
      .ld_data   (ld_data),
      .rs1       (rs1),
      .rs2       (rs2),
      .hz_stall  (hz_stall),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data);
      wr_t w;
      w.addr = addr;
      w.data = data;
      exp_q.push_back(w);
   endtask

   // Apply one cycle's inputs and move to the falling edge for sampling.
   task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldd);
      alu_valid = av;
      alu_rd    = ard;
      alu_data  = ad;
      ld_valid  = lv;
      ld_rd     = lrd;
      ld_data   = ldd;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every write on the port must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && wb_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr=%0d data=0x%0h, none expected at %0t",
                     wb_addr, wb_data, $time);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            check("wb_addr", 32'(wb_addr), 32'(w.addr));
            check("wb_data", wb_data, w.data);
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      alu_valid = 1'b0;
      alu_rd    = '0;
      alu_data  = '0;
      ld_valid  = 1'b0;
      ld_rd     = '0;
      ld_data   = '0;
      rs1       = '0;
      rs2       = '0;

      // Reset state
      #2;
      check("rst_wb_en",   32'(wb_en),    32'd0);
      check("rst_wb_addr", 32'(wb_addr),  32'd0);
      check("rst_wb_data", wb_data,       32'd0);
      check("rst_hz",      32'(hz_stall), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      tick();
      idle();
      check("ld_ready_after_reset", 32'(ld_ready), 32'd1);
      tick();

      // ALU only
      drive(1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'h0);
      expect_wr(5'd5, 32'hA5A5_A5A5);
      tick();

      // x0 from both sources: nothing written, load still accepted
      drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF);
      check("x0_ld_accepted", 32'(ld_ready), 32'd1);
      tick();
      idle();
      check("x0_no_write", 32'(wb_en),   32'd0);
      check("hold_addr",   32'(wb_addr), 32'd5);
      check("hold_data",   wb_data,      32'hA5A5_A5A5);
      tick();
      idle();
      check("x0_load_not_queued", 32'(wb_en), 32'd0);
      tick();

      // Conflict: ALU first, load one cycle later
      drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd7, 32'h0000_0011);
      expect_wr(5'd3, 32'h0000_0033);
      expect_wr(5'd7, 32'h0000_0011);
      tick();
      rs1 = 5'd7;
      rs2 = 5'd0;
      idle();
      check("hz_queue_rs1", 32'(hz_stall), 32'd1);
      rs1 = 5'd0;
      rs2 = 5'd3;
      #1;
      check("hz_wb_rs2", 32'(hz_stall), 32'd1);
      rs2 = 5'd31;
      #1;
      check("hz_none", 32'(hz_stall), 32'd0);
      rs2 = 5'd0;
      tick();
      idle();
      tick();

      // Direct load with empty queue and idle ALU
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h0000_0088);
      expect_wr(5'd8, 32'h0000_0088);
      tick();
      idle();
      tick();

      // Kill of a queued load by a younger ALU write
      drive(1'b1, 5'd1, 32'h0000_0101, 1'b1, 5'd9, 32'h0000_0099);
      expect_wr(5'd1, 32'h0000_0101);
      tick();
      drive(1'b1, 5'd9, 32'h0000_0909, 1'b0, 5'd0, 32'h0);
      expect_wr(5'd9, 32'h0000_0909);
      tick();
      idle();
      tick();
      idle();
      check("killed_pop_no_write", 32'(wb_en),   32'd0);
      check("killed_pop_addr",     32'(wb_addr), 32'd9);
      check("killed_pop_data",     wb_data,      32'h0000_0909);
      tick();

      // Kill of a load arriving in the same cycle as the ALU write
      drive(1'b1, 5'd10, 32'h0000_0AAA, 1'b1, 5'd10, 32'h0000_0BBB);
      check("same_cycle_ld_ready", 32'(ld_ready), 32'd1);
      expect_wr(5'd10, 32'h0000_0AAA);
      tick();
      idle();
      tick();
      idle();
      check("same_cycle_kill_no_write", 32'(wb_en), 32'd0);
      tick();

      // Full queue: ALU busy while four loads arrive
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'(11 + i), 32'h0000_1100 + 32'(i), 1'b1, 5'(16 + i), 32'h0000_1600 + 32'(i));
         check("fill_ld_ready", 32'(ld_ready), 32'd1);
         expect_wr(5'(11 + i), 32'h0000_1100 + 32'(i));
         tick();
      end
      drive(1'b1, 5'd15, 32'h0000_1500, 1'b1, 5'd20, 32'h0000_2000);
      check("full_ready_low", 32'(ld_ready), 32'd0);
      expect_wr(5'd15, 32'h0000_1500);
      for (int i = 0; i < 4; i++) begin
         expect_wr(5'(16 + i), 32'h0000_1600 + 32'(i));
      end
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h0000_2000);
      check("ready_low_during_first_pop", 32'(ld_ready), 32'd0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h0000_2000);
      check("ready_back_after_pop", 32'(ld_ready), 32'd1);
      expect_wr(5'd20, 32'h0000_2000);
      tick();
      for (int i = 0; i < 4; i++) begin
         idle();
         tick();
      end

      // Hazard on queued entries, then reset mid-queue
      drive(1'b1, 5'd2, 32'h0000_0022, 1'b1, 5'd4, 32'h0000_0044);
      expect_wr(5'd2, 32'h0000_0022);
      tick();
      rs1 = 5'd4;
      drive(1'b1, 5'd6, 32'h0000_0066, 1'b0, 5'd0, 32'h0);
      check("hz_queued_rs1", 32'(hz_stall), 32'd1);
      expect_wr(5'd6, 32'h0000_0066);
      tick();
      rs1 = 5'd0;
      rs2 = 5'd4;
      drive(1'b1, 5'd12, 32'h0000_00CC, 1'b0, 5'd0, 32'h0);
      check("hz_queued_rs2", 32'(hz_stall), 32'd1);
      expect_wr(5'd12, 32'h0000_00CC);
      tick();
      rs1 = 5'd4;
      rs2 = 5'd0;
      idle();
      #1 rst_n = 1'b0;
      #1;
      check("midrst_wb_en", 32'(wb_en),    32'd0);
      check("midrst_hz",    32'(hz_stall), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      tick();
      idle();
      check("post_rst_hz",       32'(hz_stall), 32'd0);
      check("post_rst_ld_ready", 32'(ld_ready), 32'd1);
      tick();
      idle();
      check("post_rst_no_stale_write", 32'(wb_en), 32'd0);
      tick();
      idle();
      tick();

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
